// File: rtl/rx_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_controller
// Description : Receive-side sequencing controller for the UART RX path.
//               Arms/re-arms the byte receiver, parses framed packets
//               (HEADER, LEN, PAYLOAD[LEN], CSUM) and commits only
//               checksum-verified payloads into a show-ahead byte FIFO.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   CLK          in   system clock
//   Rstn         in   asynchronous active-low reset
//   Enable       in   level; high allows reception
//   RX_Done_Sig  in   one-cycle strobe, RX_Data holds a received byte
//   RX_Data      in   [7:0] received byte
//   RX_En_Sig    out  receiver enable; a one-cycle low re-arms the receiver
//   Rd_En        in   FIFO pop request (ignored when empty)
//   Rd_Data      out  [7:0] FIFO head byte, valid while Rd_Empty = 0
//   Rd_Empty     out  FIFO empty flag
//   Fifo_Count   out  bytes held in the FIFO
//   Frame_Done   out  one-cycle pulse, frame fully committed
//   Frame_Err    out  one-cycle pulse, frame aborted
//   Err_Code     out  [1:0] cause of last abort:
//                     0 bad length, 1 checksum, 2 overflow, 3 timeout
// ============================================================================
module rx_frame_controller #(
  parameter int         FIFO_DEPTH  = 16,
  parameter int         MAX_LEN     = 8,
  parameter logic [7:0] HEADER      = 8'hAA,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                          CLK,
  input  logic                          Rstn,
  input  logic                          Enable,
  input  logic                          RX_Done_Sig,
  input  logic [7:0]                    RX_Data,
  output logic                          RX_En_Sig,
  input  logic                          Rd_En,
  output logic [7:0]                    Rd_Data,
  output logic                          Rd_Empty,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count,
  output logic                          Frame_Done,
  output logic                          Frame_Err,
  output logic [1:0]                    Err_Code
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  localparam int c_AW    = $clog2(FIFO_DEPTH);
  localparam int c_CW    = c_AW + 1;
  localparam int c_IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int c_LW    = $clog2(MAX_LEN + 1);
  localparam int c_SLOTS = 2 ** c_IW;
  // Idle counter only ever needs to reach TIMEOUT_CYC-1.
  localparam int c_TW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [c_TW-1:0] c_TMAX     = c_TW'(TIMEOUT_CYC - 1);
  localparam logic [c_TW-1:0] c_T_ONE    = c_TW'(1);
  localparam logic [7:0]      c_MAX_LEN  = 8'(MAX_LEN);
  localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
  localparam logic [c_IW-1:0] c_IDX_ONE  = c_IW'(1);
  localparam logic [c_LW-1:0] c_LEN_ONE  = c_LW'(1);

  localparam logic [1:0] c_ERR_LEN     = 2'd0;
  localparam logic [1:0] c_ERR_CSUM    = 2'd1;
  localparam logic [1:0] c_ERR_OVFL    = 2'd2;
  localparam logic [1:0] c_ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CSUM    = 3'd4,
    S_COMMIT  = 3'd5,
    S_ABORT   = 3'd6
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            r_state;
  logic              r_rx_en;
  logic              r_frame_done;
  logic              r_frame_err;
  logic [1:0]        r_err_code;
  logic [c_LW-1:0]   r_len;
  logic [7:0]        r_sum;
  logic [c_IW-1:0]   r_idx;
  logic [c_IW-1:0]   r_cidx;
  logic [c_TW-1:0]   r_idle_cnt;
  logic [7:0]        r_staging [c_SLOTS];

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic              w_in_frame;
  logic              w_timeout;
  logic              w_abort;
  logic [1:0]        w_abort_code;
  logic [c_CW-1:0]   w_space;
  logic              w_idx_last;
  logic              w_cidx_last;
  logic              w_wr;
  logic              w_rd;

  assign w_space     = c_DEPTH - r_count;
  assign w_idx_last  = (c_LW'(r_idx)  == (r_len - c_LEN_ONE));
  assign w_cidx_last = (c_LW'(r_cidx) == (r_len - c_LEN_ONE));

  // A write during COMMIT is skipped if Enable has just dropped; the FSM is
  // leaving for IDLE on the same edge.
  assign w_wr = (r_state == S_COMMIT) && Enable;
  assign w_rd = Rd_En && (r_count != '0);

  always_comb begin
    w_in_frame   = (r_state == S_LEN) || (r_state == S_PAYLOAD) ||
                   (r_state == S_CSUM);
    // A byte arriving on the expiry cycle wins over the timeout.
    w_timeout    = w_in_frame && !RX_Done_Sig && (r_idle_cnt == c_TMAX);
    w_abort      = 1'b0;
    w_abort_code = c_ERR_LEN;
    if (w_timeout) begin
      w_abort      = 1'b1;
      w_abort_code = c_ERR_TIMEOUT;
    end else if (RX_Done_Sig) begin
      case (r_state)
        S_LEN: begin
          if ((RX_Data == 8'h00) || (RX_Data > c_MAX_LEN)) begin
            w_abort      = 1'b1;
            w_abort_code = c_ERR_LEN;
          end
        end
        S_CSUM: begin
          if (RX_Data != r_sum) begin
            w_abort      = 1'b1;
            w_abort_code = c_ERR_CSUM;
          end else if (w_space < c_CW'(r_len)) begin
            // Space is reserved up front so COMMIT never stalls or
            // overwrites unread data; concurrent reads only add room.
            w_abort      = 1'b1;
            w_abort_code = c_ERR_OVFL;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame sequencing FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      r_state      <= S_IDLE;
      r_rx_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_code   <= c_ERR_LEN;
      r_len        <= '0;
      r_sum        <= '0;
      r_idx        <= '0;
      r_cidx       <= '0;
      r_idle_cnt   <= '0;
      r_staging    <= '{default: 8'h00};
    end else begin
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;

      // Idle counter runs only between bytes of an open frame. Entry to LEN
      // always comes from a received header, so the strobe clears it there.
      if (RX_Done_Sig || !w_in_frame) begin
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + c_T_ONE;
      end

      if (!Enable) begin
        // Silent drop of any partial frame; FIFO contents are untouched.
        r_state <= S_IDLE;
        r_rx_en <= 1'b0;
        r_idx   <= '0;
        r_cidx  <= '0;
      end else if (w_abort) begin
        r_state     <= S_ABORT;
        r_rx_en     <= 1'b0;
        r_frame_err <= 1'b1;
        r_err_code  <= w_abort_code;
        r_idx       <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_HDR;
            r_rx_en <= 1'b1;
          end
          S_HDR: begin
            if (RX_Done_Sig && (RX_Data == HEADER)) begin
              r_state <= S_LEN;
            end
          end
          S_LEN: begin
            if (RX_Done_Sig) begin
              r_len   <= RX_Data[c_LW-1:0];
              r_sum   <= RX_Data;
              r_idx   <= '0;
              r_state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            if (RX_Done_Sig) begin
              r_staging[r_idx] <= RX_Data;
              r_sum            <= r_sum + RX_Data;
              r_idx            <= r_idx + c_IDX_ONE;
              if (w_idx_last) begin
                r_state <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            if (RX_Done_Sig) begin
              r_cidx  <= '0;
              r_state <= S_COMMIT;
            end
          end
          S_COMMIT: begin
            // Byte strobes here are dropped: a UART byte time is far
            // longer than the at most MAX_LEN cycles spent in this state.
            r_cidx <= r_cidx + c_IDX_ONE;
            if (w_cidx_last) begin
              r_frame_done <= 1'b1;
              r_idx        <= '0;
              r_cidx       <= '0;
              r_state      <= S_HDR;
            end
          end
          S_ABORT: begin
            r_state <= S_HDR;
            r_rx_en <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
            r_rx_en <= 1'b0;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Payload FIFO (show-ahead)
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the count masks stale entries.
  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= r_staging[r_cidx];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign RX_En_Sig  = r_rx_en;
  assign Frame_Done = r_frame_done;
  assign Frame_Err  = r_frame_err;
  assign Err_Code   = r_err_code;
  assign Fifo_Count = r_count;
  assign Rd_Empty   = (r_count == '0);
  assign Rd_Data    = (r_count == '0) ? 8'h00 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_frame_controller
// Description : Self-checking bench for rx_frame_controller. Frames are built
//               from header/length/payload/checksum fields and their outcome
//               is predicted from the framing rules; a queue holds the
//               expected FIFO contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_controller;

  localparam int         c_DEPTH = 16;
  localparam int         c_MAX   = 8;
  localparam int         c_TMO   = 200;
  localparam logic [7:0] c_HDR   = 8'hAA;

  logic       CLK         = 1'b0;
  logic       Rstn        = 1'b0;
  logic       Enable      = 1'b0;
  logic       RX_Done_Sig = 1'b0;
  logic [7:0] RX_Data     = 8'h00;
  logic       Rd_En       = 1'b0;
  logic       RX_En_Sig;
  logic [7:0] Rd_Data;
  logic       Rd_Empty;
  logic [4:0] Fifo_Count;
  logic       Frame_Done;
  logic       Frame_Err;
  logic [1:0] Err_Code;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_err    = 0;
  int cnt_at_done = 0;

  logic [7:0] q[$];      // expected FIFO contents, head at index 0
  logic [7:0] pl [16];   // payload of the frame being sent

  always #5 CLK = ~CLK;

  rx_frame_controller #(
    .FIFO_DEPTH  (c_DEPTH),
    .MAX_LEN     (c_MAX),
    .HEADER      (c_HDR),
    .TIMEOUT_CYC (c_TMO)
  ) u_dut (
    .CLK         (CLK),
    .Rstn        (Rstn),
    .Enable      (Enable),
    .RX_Done_Sig (RX_Done_Sig),
    .RX_Data     (RX_Data),
    .RX_En_Sig   (RX_En_Sig),
    .Rd_En       (Rd_En),
    .Rd_Data     (Rd_Data),
    .Rd_Empty    (Rd_Empty),
    .Fifo_Count  (Fifo_Count),
    .Frame_Done  (Frame_Done),
    .Frame_Err   (Frame_Err),
    .Err_Code    (Err_Code)
  );

  // Pulse monitor
  always @(negedge CLK) begin
    if (Rstn) begin
      if (Frame_Done) begin
        n_done++;
        cnt_at_done = int'(Fifo_Count);
      end
      if (Frame_Err) n_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Returns at the negedge following the edge that sampled the strobe.
  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    RX_Data     = b;
    RX_Done_Sig = 1'b1;
    @(negedge CLK);
    RX_Done_Sig = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    @(negedge CLK);
    check({tag, " not empty"}, Rd_Empty, 0);
    check({tag, " data"}, Rd_Data, q[0]);
    Rd_En = 1'b1;
    @(negedge CLK);
    Rd_En = 1'b0;
    void'(q.pop_front());
  endtask

  task automatic check_reset(input string tag);
    check({tag, " rx_en"},  RX_En_Sig,  0);
    check({tag, " done"},   Frame_Done, 0);
    check({tag, " err"},    Frame_Err,  0);
    check({tag, " code"},   Err_Code,   0);
    check({tag, " count"},  Fifo_Count, 0);
    check({tag, " empty"},  Rd_Empty,   1);
    check({tag, " rddata"}, Rd_Data,    0);
  endtask

  // Send HEADER, lb, pl[0..lb-1], checksum^cx and check the outcome.
  task automatic run_frame(input logic [7:0] lb, input logic [7:0] cx, input bit pop_commit);
    int         d0;
    int         e0;
    int         L;
    logic [7:0] s;
    bit         ok;
    bit         was_empty;
    logic [1:0] exp_code;
    d0 = n_done;
    e0 = n_err;
    L  = int'(lb);
    ok = 1'b0;
    exp_code = 2'd0;
    send_byte(c_HDR);
    cyc($urandom_range(1, 4));
    send_byte(lb);
    if (L >= 1 && L <= c_MAX) begin
      s = lb;
      for (int i = 0; i < L; i++) begin
        cyc($urandom_range(1, 4));
        send_byte(pl[i]);
        s = s + pl[i];
      end
      cyc($urandom_range(1, 4));
      was_empty = (q.size() == 0);
      send_byte(s ^ cx);
      if (cx != 8'h00)                   exp_code = 2'd1;
      else if (c_DEPTH - q.size() < L)   exp_code = 2'd2;
      else                               ok = 1'b1;
    end else begin
      was_empty = (q.size() == 0);
      exp_code  = 2'd0;
    end

    if (!ok) begin
      check("abort pulse", Frame_Err, 1);
      check("abort code", Err_Code, exp_code);
      check("abort rx_en low", RX_En_Sig, 0);
      cyc(1);
      check("abort rx_en rearm", RX_En_Sig, 1);
      cyc(3);
      check("abort err count", n_err - e0, 1);
      check("abort done count", n_done - d0, 0);
    end else begin
      if (was_empty) begin
        check("commit empty before write", Rd_Empty, 1);
        cyc(1);
        check("commit empty after write", Rd_Empty, 0);
      end else if (pop_commit) begin
        check("commit pop data", Rd_Data, q[0]);
        Rd_En = 1'b1;
        @(negedge CLK);
        Rd_En = 1'b0;
        void'(q.pop_front());
      end
      for (int i = 0; i < L; i++) q.push_back(pl[i]);
      cyc(L + 4);
      check("frame done count", n_done - d0, 1);
      check("frame err count", n_err - e0, 0);
      check("count at done", cnt_at_done, q.size());
    end
    check("fifo count", Fifo_Count, q.size());
    if (q.size() > 0) check("fifo head", Rd_Data, q[0]);
  endtask

  task automatic drain();
    while (q.size() > 0) pop_check("drain");
    cyc(1);
    check("drained empty", Rd_Empty, 1);
  endtask

  initial begin
    int e0;
    int k;
    int L;
    logic [7:0] b;
    logic [7:0] cx;

    // Reset state
    cyc(3);
    check_reset("reset");
    Rstn = 1'b1;
    cyc(2);
    check("idle rx_en", RX_En_Sig, 0);
    Enable = 1'b1;
    cyc(1);
    check("enable rx_en", RX_En_Sig, 1);

    // Valid frame AA 03 11 22 33 69
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    run_frame(8'h03, 8'h00, 1'b0);
    drain();

    // Pop on empty FIFO does nothing
    @(negedge CLK);
    Rd_En = 1'b1;
    @(negedge CLK);
    Rd_En = 1'b0;
    check("empty pop count", Fifo_Count, 0);
    check("empty pop flag", Rd_Empty, 1);

    // Stray byte then bad checksum (68 instead of 69)
    send_byte(8'h55);
    cyc(3);
    run_frame(8'h03, 8'h01, 1'b0);

    // Bad lengths then a good frame
    run_frame(8'h00, 8'h00, 1'b0);
    cyc(5);
    run_frame(8'h09, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) pl[i] = 8'($urandom);
    run_frame(8'h05, 8'h00, 1'b0);
    drain();

    // Timeout inside a frame
    e0 = n_err;
    send_byte(c_HDR); cyc(2); send_byte(8'h02); cyc(2); send_byte(8'h11);
    cyc(c_TMO - 3);
    check("timeout not yet", n_err - e0, 0);
    cyc(10);
    check("timeout err", n_err - e0, 1);
    check("timeout code", Err_Code, 3);
    pl[0] = 8'h7E;
    run_frame(8'h01, 8'h00, 1'b0);
    drain();

    // Fill to 16, then overflow
    for (int i = 0; i < 8; i++) pl[i] = 8'(i + 1);
    run_frame(8'h08, 8'h00, 1'b0);
    run_frame(8'h08, 8'h00, 1'b0);
    check("full count", Fifo_Count, 16);
    pl[0] = 8'h05;
    run_frame(8'h01, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) pop_check("pop half");
    for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
    run_frame(8'h08, 8'h00, 1'b1);
    drain();

    // Randomised frames with interleaved pops
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom);
        if (b == c_HDR) b = 8'h55;
        send_byte(b);
        cyc(2);
      end
      if ($urandom_range(0, 7) == 0) L = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(9, 12));
      else                           L = int'($urandom_range(1, c_MAX));
      for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
      cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame(8'(L), cx, (q.size() > 0) && ($urandom_range(0, 1) == 1));
      k = int'($urandom_range(0, q.size()));
      for (int i = 0; i < k; i++) pop_check("rand pop");
      cyc(2);
    end
    drain();

    // Enable drop mid-payload: silent, FIFO kept
    pl[0] = 8'h3C;
    run_frame(8'h01, 8'h00, 1'b0);
    e0 = n_err;
    send_byte(c_HDR); cyc(2); send_byte(8'h04); cyc(2);
    send_byte(8'h11); cyc(2); send_byte(8'h22);
    Enable = 1'b0;
    cyc(1);
    check("disable rx_en", RX_En_Sig, 0);
    cyc(3);
    check("disable no err", n_err - e0, 0);
    check("disable count kept", Fifo_Count, q.size());
    Enable = 1'b1;
    cyc(2);
    check("reenable rx_en", RX_En_Sig, 1);
    pl[0] = 8'hC3; pl[1] = 8'h5A;
    run_frame(8'h02, 8'h00, 1'b0);
    drain();

    // Reset asserted mid-COMMIT
    for (int i = 0; i < 6; i++) pl[i] = 8'($urandom);
    b = 8'h06;
    send_byte(c_HDR); cyc(2); send_byte(8'h06);
    for (int i = 0; i < 6; i++) begin
      cyc(2);
      send_byte(pl[i]);
      b = b + pl[i];
    end
    cyc(2);
    send_byte(b);
    cyc(2);
    check("mid commit count", Fifo_Count, 2);
    #2 Rstn = 1'b0;
    #1 check_reset("async reset");
    q.delete();
    @(negedge CLK);
    Rstn = 1'b1;
    cyc(3);
    check("post reset count", Fifo_Count, 0);
    check("post reset rx_en", RX_En_Sig, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
